vram_oam_arbiter: RTL and testbench
===================================

# vram_oam_arbiter

Shares the single VRAM/OAM memory port between the PPU fetchers, the CPU, and an internal OAM DMA engine triggered by writes to FF46. It applies the DMG access-blocking rules per PPU mode and sequences the 160-byte OAM DMA copy. It sits between the PPU, the CPU bus decoder and the VRAM/OAM RAM.

## Interface
- DMA_LEN, 160, bytes copied per DMA.
- DMA_BYTE_CYCLES, 4, clocks per DMA byte; must be ≥ 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- lcd_en  in  1  LCDC[7].
- ppu_mode  in  2  0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
- ppu_rd  in  1  PPU read request.
- ppu_addr  in  16  PPU address.
- ppu_rdata  out  8  PPU read data.
- cpu_rd / cpu_wr  in  1  CPU strobes, only for 8000–9FFF and FE00–FE9F.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data.
- cpu_blocked  out  1  current CPU access dropped.
- dma_start  in  1  one-cycle pulse on a CPU write to FF46.
- dma_page  in  8  FF46 value.
- dma_active  out  1  DMA in progress.
- src_rd  out  1  DMA source read strobe to the system bus.
- src_addr  out  16  DMA source address.
- src_rdata  in  8  source data, valid the cycle after src_rd.
- mem_rd / mem_wr  out  1  RAM strobes.
- mem_addr  out  16  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM data, valid the cycle after mem_rd.

## Operation
**Grant logic** (combinational, one owner per cycle, fixed priority DMA write > PPU > CPU):
- A DMA write cycle drives mem_wr=1, mem_addr=FE00+idx, mem_wdata=src_rdata.
- The PPU is granted when ppu_rd=1, lcd_en=1 and there is no DMA write that cycle. If the PPU loses the slot, ppu_rdata=FF the next cycle.

**CPU blocking.** A CPU access is blocked (cpu_blocked=1, write dropped, read returns FF) when any of these holds:
- address is OAM and (dma_active, or lcd_en and ppu_mode ∈ {SCAN, DRAW});
- address is VRAM and lcd_en and ppu_mode=DRAW;
- the PPU or DMA holds the slot.

An address outside both ranges is ignored and reads FF. With lcd_en=0, the CPU has full access except OAM during DMA.

**Read return.** A registered owner tag (NONE/PPU/CPU) records the cycle's read grant. Next cycle, the owner receives mem_rdata and the non-owner receives FF.

**DMA FSM** (states IDLE, RD, WR, WAIT), with idx 8-bit and cnt a per-byte cycle counter:
- **IDLE:** dma_start → RD, idx=0, cnt=0, latch the page. A page ≥ E0 is latched as page−20h (echo).
- **RD:** src_rd=1, src_addr={page, idx}; → WR.
- **WR:** issue the mem write; → WAIT, or → RD if DMA_BYTE_CYCLES=2.
- **WAIT:** hold until cnt=DMA_BYTE_CYCLES−1. Then idx+1 and → RD; if idx=DMA_LEN−1, → IDLE.
- dma_start in any non-IDLE state restarts at RD with idx=0 and the new page.

## Timing
- **Reset:** dma_active=0, src_rd=0, mem_wr=0, mem_rd=0, owner=NONE, cpu_rdata=FF, ppu_rdata=FF, FSM=IDLE. mem_wr is forced to 0 while rst is low.
- **Reset mid-DMA:** abort immediately. OAM bytes already written stay written; no resume.
- **DMA start:**
  - dma_start at cycle N → dma_active=1 and src_rd=1 at N+1.
  - First OAM write at N+2.
  - dma_active stays high for exactly DMA_LEN×DMA_BYTE_CYCLES cycles (640 by default), falling at N+641.
- **Read latency:** PPU and CPU reads return data 1 cycle after the request. The grant is decided in the request cycle.
- **Simultaneous events:**
  - A DMA write and a PPU OAM read in the same cycle: the PPU gets FF.
  - A CPU write and a PPU read in the same cycle: the CPU write is dropped.
  - A ppu_mode change applies to blocking in the same cycle.

## Structure
- Shared package ppu_pkg:
  - PPU_STATES_t (existing mode encoding);
  - DMA_STATES_t {DMA_IDLE, DMA_RD, DMA_WR, DMA_WAIT};
  - owner enum;
  - constants OAM_BASE_ADDR, OAM_END_ADDR, VRAM_BASE_ADDR, VRAM_END_ADDR.
- Sub-module oam_dma_engine contains the FSM, idx, cnt and page latch. Its outputs are dma_active, src_*, and a dma_wr_req/dma_wr_addr/dma_wr_data triple. The top level holds the grant mux, the blocking rules and the owner register.

## Test plan
- **DMA copy:** preload source page C1 with pattern i^5Ah, pulse dma_start with page C1 → 160 OAM writes FE00+i=i^5Ah, each 4 cycles apart; dma_active high for exactly 640 cycles.
- **Blocking:** lcd_en=1. In mode 3, CPU read 8000 → FF and CPU write 9800 dropped. In mode 0, same accesses succeed. In mode 2, CPU read FE10 → FF.
- **Collision:** during DMA, PPU reads FE04 in a write cycle → ppu_rdata=FF; in a WAIT cycle → real data. CPU write FE00 during DMA is dropped.
- **Restart:** dma_start with page C0, then at cycle 100 dma_start with page D0 → idx resets to 0, final OAM holds the D0 page, dma_active falls 640 cycles after the second pulse.
- **Echo/reset:** page E2 → source addresses C2xx. Deassert rst at idx=50 → all outputs at reset values, FE00–FE31 hold copied data, FE32 unchanged.

Source files
------------

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU/arbiter types and memory map constants
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_RD,
    DMA_WR,
    DMA_WAIT
  } DMA_STATES_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_PPU,
    OWN_CPU
  } owner_t;

  localparam logic [15:0] OAM_BASE_ADDR  = 16'hFE00;
  localparam logic [15:0] OAM_END_ADDR   = 16'hFE9F;
  localparam logic [15:0] VRAM_BASE_ADDR = 16'h8000;
  localparam logic [15:0] VRAM_END_ADDR  = 16'h9FFF;

  // Pages E0-FF alias the work RAM at C0-DF.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA sequencer: one source read and one OAM write per byte slot
module oam_dma_engine
  import ppu_pkg::*;
#(
  parameter int DMA_LEN         = 160,
  parameter int DMA_BYTE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_page,
  input  logic [7:0]  i_src_rdata,
  output logic        o_active,
  output logic        o_src_rd,
  output logic [15:0] o_src_addr,
  output logic        o_wr_req,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [7:0] LAST_CNT = 8'(DMA_BYTE_CYCLES - 1);

  DMA_STATES_t r_state;
  logic [7:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [7:0]  r_page;
  logic        r_active;
  logic        r_src_rd;
  logic        r_wr_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= DMA_IDLE;
      r_idx    <= 8'h00;
      r_cnt    <= 8'h00;
      r_page   <= 8'h00;
      r_active <= 1'b0;
      r_src_rd <= 1'b0;
      r_wr_req <= 1'b0;
    end else begin
      r_src_rd <= 1'b0;
      r_wr_req <= 1'b0;
      // A start pulse always wins, including a restart mid-copy.
      if (i_start) begin
        r_state  <= DMA_RD;
        r_idx    <= 8'h00;
        r_cnt    <= 8'h00;
        r_page   <= dma_src_page(i_page);
        r_active <= 1'b1;
        r_src_rd <= 1'b1;
      end else begin
        case (r_state)
          DMA_IDLE: r_active <= 1'b0;
          DMA_RD: begin
            r_state  <= DMA_WR;
            r_cnt    <= r_cnt + 8'h01;
            r_wr_req <= 1'b1;
          end
          DMA_WR, DMA_WAIT: begin
            if (r_cnt == LAST_CNT) begin
              r_cnt <= 8'h00;
              if (r_idx == LAST_IDX) begin
                r_state  <= DMA_IDLE;
                r_active <= 1'b0;
              end else begin
                r_idx    <= r_idx + 8'h01;
                r_state  <= DMA_RD;
                r_src_rd <= 1'b1;
              end
            end else begin
              r_cnt   <= r_cnt + 8'h01;
              r_state <= DMA_WAIT;
            end
          end
          default: r_state <= DMA_IDLE;
        endcase
      end
    end
  end

  assign o_active   = r_active;
  assign o_src_rd   = r_src_rd;
  assign o_src_addr = {r_page, r_idx};
  assign o_wr_req   = r_wr_req;
  assign o_wr_addr  = OAM_BASE_ADDR + {8'h00, r_idx};
  assign o_wr_data  = i_src_rdata;

endmodule

// File: rtl/vram_oam_arbiter.sv
// rtl/vram_oam_arbiter.sv - VRAM/OAM port arbiter: DMA write > PPU > CPU with DMG mode blocking
module vram_oam_arbiter
  import ppu_pkg::*;
#(
  parameter int DMA_LEN         = 160,
  parameter int DMA_BYTE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lcd_en,
  input  logic [1:0]  i_ppu_mode,
  input  logic        i_ppu_rd,
  input  logic [15:0] i_ppu_addr,
  output logic [7:0]  o_ppu_rdata,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_blocked,
  input  logic        i_dma_start,
  input  logic [7:0]  i_dma_page,
  output logic        o_dma_active,
  output logic        o_src_rd,
  output logic [15:0] o_src_addr,
  input  logic [7:0]  i_src_rdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata
);

  PPU_STATES_t w_mode;
  logic        w_dma_wr;
  logic [15:0] w_dma_wr_addr;
  logic [7:0]  w_dma_wr_data;
  logic        w_ppu_grant;
  logic        w_cpu_oam;
  logic        w_cpu_vram;
  logic        w_cpu_req;
  logic        w_rule_block;
  logic        w_cpu_grant;
  owner_t      r_owner;

  oam_dma_engine #(
    .DMA_LEN         (DMA_LEN),
    .DMA_BYTE_CYCLES (DMA_BYTE_CYCLES)
  ) u_dma (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_dma_start),
    .i_page      (i_dma_page),
    .i_src_rdata (i_src_rdata),
    .o_active    (o_dma_active),
    .o_src_rd    (o_src_rd),
    .o_src_addr  (o_src_addr),
    .o_wr_req    (w_dma_wr),
    .o_wr_addr   (w_dma_wr_addr),
    .o_wr_data   (w_dma_wr_data)
  );

  assign w_mode      = PPU_STATES_t'(i_ppu_mode);
  assign w_ppu_grant = i_ppu_rd && i_lcd_en && !w_dma_wr;

  assign w_cpu_oam  = (i_cpu_addr >= OAM_BASE_ADDR) && (i_cpu_addr <= OAM_END_ADDR);
  assign w_cpu_vram = (i_cpu_addr >= VRAM_BASE_ADDR) && (i_cpu_addr <= VRAM_END_ADDR);
  assign w_cpu_req  = (i_cpu_rd || i_cpu_wr) && (w_cpu_oam || w_cpu_vram);

  // Losing the slot to the PPU or a DMA write blocks the CPU like a mode rule does.
  assign w_rule_block =
      (w_cpu_oam && (o_dma_active || (i_lcd_en && (w_mode == SCAN || w_mode == DRAW)))) ||
      (w_cpu_vram && i_lcd_en && (w_mode == DRAW)) ||
      w_dma_wr || w_ppu_grant;

  assign o_cpu_blocked = w_cpu_req && w_rule_block;
  assign w_cpu_grant   = w_cpu_req && !w_rule_block;

  // Strobes are gated by reset so no write can slip through while held in reset.
  assign o_mem_wr    = i_rst_n && (w_dma_wr || (w_cpu_grant && i_cpu_wr));
  assign o_mem_rd    = i_rst_n && (w_ppu_grant || (w_cpu_grant && i_cpu_rd));
  assign o_mem_addr  = w_dma_wr ? w_dma_wr_addr : (w_ppu_grant ? i_ppu_addr : i_cpu_addr);
  assign o_mem_wdata = w_dma_wr ? w_dma_wr_data : i_cpu_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= OWN_NONE;
    end else if (w_ppu_grant) begin
      r_owner <= OWN_PPU;
    end else if (w_cpu_grant && i_cpu_rd) begin
      r_owner <= OWN_CPU;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  assign o_ppu_rdata = (r_owner == OWN_PPU) ? i_mem_rdata : 8'hFF;
  assign o_cpu_rdata = (r_owner == OWN_CPU) ? i_mem_rdata : 8'hFF;

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// tb/tb_vram_oam_arbiter.sv - self-checking bench for vram_oam_arbiter
module tb_vram_oam_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_en = 1'b0;
  logic [1:0]  ppu_mode = 2'd0;
  logic        ppu_rd = 1'b0;
  logic [15:0] ppu_addr = 16'h0000;
  logic [7:0]  ppu_rdata;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_blocked;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic        dma_active;
  logic        src_rd;
  logic [15:0] src_addr;
  logic [7:0]  src_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  sysmem [0:65535];
  logic [7:0]  ram    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;

  int checks = 0;
  int errors = 0;

  vram_oam_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_lcd_en      (lcd_en),
    .i_ppu_mode    (ppu_mode),
    .i_ppu_rd      (ppu_rd),
    .i_ppu_addr    (ppu_addr),
    .o_ppu_rdata   (ppu_rdata),
    .i_cpu_rd      (cpu_rd),
    .i_cpu_wr      (cpu_wr),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_wdata   (cpu_wdata),
    .o_cpu_rdata   (cpu_rdata),
    .o_cpu_blocked (cpu_blocked),
    .i_dma_start   (dma_start),
    .i_dma_page    (dma_page),
    .o_dma_active  (dma_active),
    .o_src_rd      (src_rd),
    .o_src_addr    (src_addr),
    .i_src_rdata   (src_rdata),
    .o_mem_rd      (mem_rd),
    .o_mem_wr      (mem_wr),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // VRAM/OAM RAM and system bus models: data returned the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (src_rd) src_rdata <= sysmem[src_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    step();
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic cpu_access(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [7:0] d, output logic blk, output logic [7:0] rdata);
    step();
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    blk = cpu_blocked;
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(negedge clk);
    rdata = cpu_rdata;
  endtask

  task automatic test_reset();
    cpu_wr = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h12;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({dma_active, src_rd, mem_wr, mem_rd} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: active/src_rd/mem_wr/mem_rd=%b want 0000",
               {dma_active, src_rd, mem_wr, mem_rd});
    end
    checks++;
    if (cpu_rdata !== 8'hFF || ppu_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL reset_rdata: cpu=%h ppu=%h want FF FF", cpu_rdata, ppu_rdata);
    end
    step();
    cpu_wr = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_blocking();
    logic blk;
    logic [7:0] rd;
    preload(16'h8000, 8'h3C);
    preload(16'h9800, 8'h11);
    preload(16'hFE10, 8'h77);
    lcd_en = 1'b1; ppu_mode = 2'd3;
    cpu_access(1'b1, 1'b0, 16'h8000, 8'h00, blk, rd);
    checks++;
    if (blk !== 1'b1 || rd !== 8'hFF) begin
      errors++; $display("FAIL blk_m3_rd: blocked=%b data=%h want 1 FF", blk, rd);
    end
    cpu_access(1'b0, 1'b1, 16'h9800, 8'hA5, blk, rd);
    checks++;
    if (blk !== 1'b1 || ram[16'h9800] !== 8'h11) begin
      errors++; $display("FAIL blk_m3_wr: blocked=%b ram=%h want 1 11", blk, ram[16'h9800]);
    end
    ppu_mode = 2'd0;
    cpu_access(1'b1, 1'b0, 16'h8000, 8'h00, blk, rd);
    checks++;
    if (blk !== 1'b0 || rd !== 8'h3C) begin
      errors++; $display("FAIL blk_m0_rd: blocked=%b data=%h want 0 3C", blk, rd);
    end
    cpu_access(1'b0, 1'b1, 16'h9800, 8'hA5, blk, rd);
    checks++;
    if (blk !== 1'b0 || ram[16'h9800] !== 8'hA5) begin
      errors++; $display("FAIL blk_m0_wr: blocked=%b ram=%h want 0 A5", blk, ram[16'h9800]);
    end
    shadow[16'h9800] = 8'hA5;
    ppu_mode = 2'd2;
    cpu_access(1'b1, 1'b0, 16'hFE10, 8'h00, blk, rd);
    checks++;
    if (blk !== 1'b1 || rd !== 8'hFF) begin
      errors++; $display("FAIL blk_m2_oam: blocked=%b data=%h want 1 FF", blk, rd);
    end
    cpu_access(1'b1, 1'b0, 16'h8000, 8'h00, blk, rd);
    checks++;
    if (blk !== 1'b0 || rd !== 8'h3C) begin
      errors++; $display("FAIL blk_m2_vram: blocked=%b data=%h want 0 3C", blk, rd);
    end
    lcd_en = 1'b0; ppu_mode = 2'd3;
    cpu_access(1'b1, 1'b0, 16'hFE10, 8'h00, blk, rd);
    checks++;
    if (blk !== 1'b0 || rd !== 8'h77) begin
      errors++; $display("FAIL blk_lcd_off: blocked=%b data=%h want 0 77", blk, rd);
    end
    ppu_mode = 2'd0;
  endtask

  // Random CPU/PPU traffic against a rule-level model of grants and a shadow memory.
  task automatic test_random();
    logic [7:0] exp_ppu, exp_cpu;
    logic ppu_g, oam, vram, inr, exp_blk;
    int op;
    for (int i = 0; i < 16; i++) begin
      preload(16'h8000 + 16'(i), 8'($urandom_range(0, 254)));
      preload(16'hFE00 + 16'(i), 8'($urandom_range(0, 254)));
    end
    exp_ppu = 8'hFF; exp_cpu = 8'hFF;
    for (int t = 0; t < 300; t++) begin
      step();
      lcd_en   = 1'($urandom_range(0, 1));
      ppu_mode = 2'($urandom_range(0, 3));
      ppu_rd   = 1'($urandom_range(0, 1));
      ppu_addr = ($urandom_range(0, 1) != 0 ? 16'h8000 : 16'hFE00) + 16'($urandom_range(0, 15));
      op       = int'($urandom_range(0, 2));
      cpu_rd   = (op == 1);
      cpu_wr   = (op == 2);
      case ($urandom_range(0, 2))
        0: cpu_addr = 16'h8000 + 16'($urandom_range(0, 15));
        1: cpu_addr = 16'hFE00 + 16'($urandom_range(0, 15));
        default: cpu_addr = 16'hC000 + 16'($urandom_range(0, 15));
      endcase
      cpu_wdata = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (ppu_rdata !== exp_ppu || cpu_rdata !== exp_cpu) begin
        errors++;
        $display("FAIL rand_rdata t=%0d: ppu=%h cpu=%h want %h %h", t, ppu_rdata, cpu_rdata,
                 exp_ppu, exp_cpu);
      end
      ppu_g = ppu_rd && lcd_en;
      oam   = (cpu_addr >= 16'hFE00 && cpu_addr <= 16'hFE9F);
      vram  = (cpu_addr >= 16'h8000 && cpu_addr <= 16'h9FFF);
      inr   = oam || vram;
      exp_blk = (oam && lcd_en && ppu_mode >= 2'd2) || (vram && lcd_en && ppu_mode == 2'd3) || ppu_g;
      if (op != 0 && inr) begin
        checks++;
        if (cpu_blocked !== exp_blk) begin
          errors++;
          $display("FAIL rand_blocked t=%0d addr=%h: got %b want %b", t, cpu_addr, cpu_blocked, exp_blk);
        end
      end
      exp_ppu = ppu_g ? shadow[ppu_addr] : 8'hFF;
      exp_cpu = (op == 1 && inr && !exp_blk) ? shadow[cpu_addr] : 8'hFF;
      if (op == 2 && inr && !exp_blk) shadow[cpu_addr] = cpu_wdata;
    end
    step();
    ppu_rd = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; lcd_en = 1'b0; ppu_mode = 2'd0;
    @(negedge clk);
    checks++;
    if (ppu_rdata !== exp_ppu || cpu_rdata !== exp_cpu) begin
      errors++;
      $display("FAIL rand_rdata_last: ppu=%h cpu=%h want %h %h", ppu_rdata, cpu_rdata, exp_ppu, exp_cpu);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ram[16'h8000 + 16'(i)] !== shadow[16'h8000 + 16'(i)] ||
          ram[16'hFE00 + 16'(i)] !== shadow[16'hFE00 + 16'(i)]) begin
        errors++;
        $display("FAIL rand_mem[%0d]: vram=%h oam=%h want %h %h", i, ram[16'h8000 + 16'(i)],
                 ram[16'hFE00 + 16'(i)], shadow[16'h8000 + 16'(i)], shadow[16'hFE00 + 16'(i)]);
      end
    end
  endtask

  task automatic test_dma_copy();
    int wcnt = 0, act_cnt = 0, act_first = -1, act_last = -1;
    for (int t = 0; t <= 700; t++) begin
      step();
      dma_start = (t == 0); dma_page = 8'hC1;
      @(negedge clk);
      if (dma_active === 1'b1) begin
        act_cnt++;
        if (act_first < 0) act_first = t;
        act_last = t;
      end
      if (t == 1) begin
        checks++;
        if (src_rd !== 1'b1 || src_addr !== 16'hC100) begin
          errors++; $display("FAIL copy_first_src: src_rd=%b addr=%h want 1 C100", src_rd, src_addr);
        end
      end
      if (mem_wr === 1'b1) begin
        checks++;
        if (t != 2 + 4 * wcnt || mem_addr !== 16'hFE00 + 16'(wcnt) || mem_wdata !== (8'(wcnt) ^ 8'h5A)) begin
          errors++;
          $display("FAIL copy_write%0d: t=%0d addr=%h data=%h want t=%0d addr=%h data=%h", wcnt, t,
                   mem_addr, mem_wdata, 2 + 4 * wcnt, 16'hFE00 + 16'(wcnt), 8'(wcnt) ^ 8'h5A);
        end
        wcnt++;
      end
    end
    checks++;
    if (wcnt != 160) begin errors++; $display("FAIL copy_count: got %0d want 160", wcnt); end
    checks++;
    if (act_first != 1 || act_cnt != 640 || act_last != 640) begin
      errors++;
      $display("FAIL copy_active: first=%0d cycles=%0d last=%0d want 1 640 640", act_first, act_cnt, act_last);
    end
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (ram[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) begin
        errors++; $display("FAIL copy_oam[%0d]: got %h want %h", i, ram[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_collision();
    lcd_en = 1'b1; ppu_mode = 2'd0;
    for (int t = 0; t <= 660; t++) begin
      step();
      dma_start = (t == 0); dma_page = 8'hC1;
      ppu_rd = (t == 2) || (t == 4); ppu_addr = 16'hFE04;
      cpu_wr = (t == 5); cpu_addr = 16'hFE00; cpu_wdata = 8'h33;
      @(negedge clk);
      if (t == 2) begin
        checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'hFE00) begin
          errors++; $display("FAIL coll_dma_owns: wr=%b rd=%b addr=%h want 1 0 FE00", mem_wr, mem_rd, mem_addr);
        end
      end
      if (t == 3) begin
        checks++;
        if (ppu_rdata !== 8'hFF) begin errors++; $display("FAIL coll_ppu_lost: got %h want FF", ppu_rdata); end
      end
      if (t == 5) begin
        checks++;
        if (ppu_rdata !== (8'h04 ^ 8'h5A)) begin
          errors++; $display("FAIL coll_ppu_wait: got %h want %h", ppu_rdata, 8'h04 ^ 8'h5A);
        end
        checks++;
        if (cpu_blocked !== 1'b1) begin errors++; $display("FAIL coll_cpu_oam: blocked=%b want 1", cpu_blocked); end
      end
    end
    checks++;
    if (ram[16'hFE00] !== 8'h5A) begin errors++; $display("FAIL coll_fe00: got %h want 5A", ram[16'hFE00]); end
    lcd_en = 1'b0;
  endtask

  task automatic test_restart();
    int act_cnt = 0, act_last = -1;
    for (int t = 0; t <= 760; t++) begin
      step();
      dma_start = (t == 0) || (t == 100);
      dma_page  = (t < 100) ? 8'hC0 : 8'hD0;
      @(negedge clk);
      if (dma_active === 1'b1) begin act_cnt++; act_last = t; end
      if (t == 101) begin
        checks++;
        if (src_rd !== 1'b1 || src_addr !== 16'hD000) begin
          errors++; $display("FAIL restart_src: src_rd=%b addr=%h want 1 D000", src_rd, src_addr);
        end
      end
      if (t == 102) begin
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 16'hFE00 || mem_wdata !== sysmem[16'hD000]) begin
          errors++;
          $display("FAIL restart_wr: wr=%b addr=%h data=%h want 1 FE00 %h", mem_wr, mem_addr, mem_wdata,
                   sysmem[16'hD000]);
        end
      end
    end
    checks++;
    if (act_cnt != 740 || act_last != 740) begin
      errors++; $display("FAIL restart_active: cycles=%0d last=%0d want 740 740", act_cnt, act_last);
    end
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (ram[16'hFE00 + 16'(i)] !== sysmem[16'hD000 + 16'(i)]) begin
        errors++;
        $display("FAIL restart_oam[%0d]: got %h want %h", i, ram[16'hFE00 + 16'(i)], sysmem[16'hD000 + 16'(i)]);
      end
    end
  endtask

  task automatic test_echo_reset();
    int after = 0;
    for (int t = 0; t <= 230; t++) begin
      step();
      dma_start = (t == 0); dma_page = 8'hE2;
      if (t == 201) rst_n = 1'b0;
      if (t == 205) rst_n = 1'b1;
      @(negedge clk);
      if (src_rd === 1'b1 && t < 201) begin
        checks++;
        if (src_addr !== {8'hC2, 8'((t - 1) / 4)}) begin
          errors++; $display("FAIL echo_src t=%0d: got %h want %h", t, src_addr, {8'hC2, 8'((t - 1) / 4)});
        end
      end
      if (t == 201) begin
        checks++;
        if ({dma_active, src_rd, mem_wr, mem_rd} !== 4'b0000 || cpu_rdata !== 8'hFF || ppu_rdata !== 8'hFF) begin
          errors++;
          $display("FAIL midreset_outputs: act/src/wr/rd=%b cpu=%h ppu=%h want 0000 FF FF",
                   {dma_active, src_rd, mem_wr, mem_rd}, cpu_rdata, ppu_rdata);
        end
      end
      if (t > 205 && (dma_active === 1'b1 || mem_wr === 1'b1 || src_rd === 1'b1)) after++;
    end
    checks++;
    if (after != 0) begin errors++; $display("FAIL midreset_resume: active cycles after reset=%0d want 0", after); end
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (ram[16'hFE00 + 16'(i)] !== sysmem[16'hC200 + 16'(i)]) begin
        errors++;
        $display("FAIL echo_oam[%0d]: got %h want %h", i, ram[16'hFE00 + 16'(i)], sysmem[16'hC200 + 16'(i)]);
      end
    end
    checks++;
    if (ram[16'hFE32] !== sysmem[16'hD032]) begin
      errors++; $display("FAIL midreset_fe32: got %h want %h", ram[16'hFE32], sysmem[16'hD032]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sysmem[16'hC000 + 16'(i)] = 8'($urandom_range(0, 255));
      sysmem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      sysmem[16'hC200 + 16'(i)] = 8'($urandom_range(0, 255));
      sysmem[16'hD000 + 16'(i)] = 8'($urandom_range(0, 255));
    end
    test_reset();
    test_blocking();
    test_random();
    test_dma_copy();
    test_collision();
    test_restart();
    test_echo_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
